// File: rtl/fft_feed_pkg.sv
// Shared FSM state type and constants for the FFT frame feeder.
package fft_feed_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CFG    = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam int unsigned FWD_INV_BIT = 0;
    localparam int unsigned FRAME_CNT_W = 16;

    function automatic int unsigned frame_len(input int unsigned n_log2);
        return 1 << n_log2;
    endfunction

endpackage

// File: rtl/fft_frame_feeder_if.sv
// AXI4-Stream config and data channels between the frame feeder and the FFT core.
interface fft_frame_feeder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CFG_W  = 8
);
    localparam int unsigned SAMPLE_W = 2 * DATA_W;

    logic [CFG_W-1:0]    m_axis_config_tdata;
    logic                m_axis_config_tvalid;
    logic                m_axis_config_tready;
    logic [SAMPLE_W-1:0] m_axis_data_tdata;
    logic                m_axis_data_tvalid;
    logic                m_axis_data_tready;
    logic                m_axis_data_tlast;

    modport master (
        output m_axis_config_tdata, m_axis_config_tvalid,
        input  m_axis_config_tready,
        output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        input  m_axis_data_tready
    );

    modport slave (
        input  m_axis_config_tdata, m_axis_config_tvalid,
        output m_axis_config_tready,
        input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        output m_axis_data_tready
    );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry register skid buffer: full throughput, registered outputs, upstream ready from a register.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             sk_vld;
    logic [WIDTH-1:0] sk_data;

    assign s_ready = ~sk_vld;

    // Output register refills from the skid entry first, so beat order is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            sk_vld  <= 1'b0;
            sk_data <= '0;
        end else if (!m_valid || m_ready) begin
            if (sk_vld) begin
                m_data  <= sk_data;
                m_valid <= 1'b1;
                sk_vld  <= 1'b0;
            end else begin
                m_valid <= s_valid;
                if (s_valid) m_data <= s_data;
            end
        end else if (s_valid && !sk_vld) begin
            sk_data <= s_data;
            sk_vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Framed AXI4-Stream sample source for the FFT core: one config beat, then NUM_FRAMES buffered frames.
// Optional FFT_FEED_LOOP_EN adds a loop input that restarts streaming without re-issuing config.
module fft_frame_feeder
    import fft_feed_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned N_LOG2     = 10,
    parameter int unsigned NUM_FRAMES = 1,
    parameter int unsigned CFG_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef FFT_FEED_LOOP_EN
    input  logic                     loop,
`endif
    input  logic                     start,
    input  logic                     inv,
    input  logic                     wr_en,
    input  logic [N_LOG2-1:0]        wr_addr,
    input  logic [2*DATA_W-1:0]      wr_data,
    fft_frame_feeder_if.master       axis,
    output logic                     busy,
    output logic [FRAME_CNT_W-1:0]   frame_cnt,
    output logic                     done
);

    localparam int unsigned SAMPLE_W = 2 * DATA_W;
    localparam int unsigned FLEN     = frame_len(N_LOG2);
    localparam logic [N_LOG2-1:0]      LAST_ADDR  = N_LOG2'(FLEN - 1);
    localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(NUM_FRAMES - 1);

    state_e                 state;
    logic                   cfg_tvalid;
    logic [CFG_W-1:0]       cfg_tdata;
    logic [N_LOG2-1:0]      rd_addr;
    logic [FRAME_CNT_W-1:0] iss_frames;
    logic [FRAME_CNT_W-1:0] pass_frames;
    logic                   iss_done;
    logic                   rd_vld;
    logic                   rd_last;
    logic [SAMPLE_W-1:0]    rd_data;
    logic [SAMPLE_W-1:0]    mem [FLEN];
    logic                   sk_ready;
    logic                   out_valid;
    logic [SAMPLE_W:0]      out_bus;
    logic                   out_last;
    logic                   loop_c;
    logic                   rd_issue_c;
    logic                   out_hs_c;
    logic                   final_hs_c;

`ifdef FFT_FEED_LOOP_EN
    assign loop_c = loop;
`else
    assign loop_c = 1'b0;
`endif

    assign out_last   = out_bus[SAMPLE_W];
    assign rd_issue_c = (state == S_STREAM) && !iss_done && (!rd_vld || sk_ready);
    assign out_hs_c   = out_valid && axis.m_axis_data_tready;
    assign final_hs_c = out_hs_c && out_last && (pass_frames == LAST_FRAME);

    assign axis.m_axis_config_tvalid = cfg_tvalid;
    assign axis.m_axis_config_tdata  = cfg_tdata;
    assign axis.m_axis_data_tvalid   = out_valid;
    assign axis.m_axis_data_tdata    = out_bus[SAMPLE_W-1:0];
    assign axis.m_axis_data_tlast    = out_last;

    // Sample buffer: frozen while busy, synchronous read feeding the read stage.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) mem[wr_addr] <= wr_data;
        if (rd_issue_c)     rd_data      <= mem[rd_addr];
    end

    // Read stage valid; holds its beat until the skid buffer can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
        end else if (rd_issue_c) begin
            rd_vld  <= 1'b1;
            rd_last <= (rd_addr == LAST_ADDR);
        end else if (sk_ready) begin
            rd_vld  <= 1'b0;
        end
    end

    axis_skid_buf #(
        .WIDTH (SAMPLE_W + 1)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (rd_vld),
        .s_ready (sk_ready),
        .s_data  ({rd_last, rd_data}),
        .m_valid (out_valid),
        .m_ready (axis.m_axis_data_tready),
        .m_data  (out_bus)
    );

    // Run control FSM with registered status and config outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cfg_tvalid  <= 1'b0;
            cfg_tdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_cnt   <= '0;
            rd_addr     <= '0;
            iss_frames  <= '0;
            iss_done    <= 1'b0;
            pass_frames <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_CFG;
                        cfg_tvalid  <= 1'b1;
                        cfg_tdata   <= CFG_W'(!inv) << FWD_INV_BIT;
                        busy        <= 1'b1;
                        frame_cnt   <= '0;
                        rd_addr     <= '0;
                        iss_frames  <= '0;
                        iss_done    <= 1'b0;
                        pass_frames <= '0;
                    end
                end
                S_CFG: begin
                    if (axis.m_axis_config_tready) begin
                        state      <= S_STREAM;
                        cfg_tvalid <= 1'b0;
                        cfg_tdata  <= '0;
                    end
                end
                S_STREAM: begin
                    if (rd_issue_c) begin
                        rd_addr <= rd_addr + N_LOG2'(1);
                        if (rd_addr == LAST_ADDR) begin
                            iss_frames <= iss_frames + FRAME_CNT_W'(1);
                            if (iss_frames == LAST_FRAME) iss_done <= 1'b1;
                        end
                    end
                    if (out_hs_c && out_last) begin
                        frame_cnt   <= frame_cnt + FRAME_CNT_W'(1);
                        pass_frames <= pass_frames + FRAME_CNT_W'(1);
                    end
                    // Pipeline is empty here, so a loop restart can reuse the idle counters.
                    if (final_hs_c) begin
                        if (loop_c) begin
                            rd_addr     <= '0;
                            iss_frames  <= '0;
                            iss_done    <= 1'b0;
                            pass_frames <= '0;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed/randomised bench for fft_frame_feeder against a frame-level reference model.
// Loop-mode steps are built only when FFT_FEED_LOOP_EN is defined.
module tb_fft_frame_feeder;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned N_LOG2     = 8;
    localparam int unsigned NUM_FRAMES = 3;
    localparam int unsigned CFG_W      = 8;
    localparam int unsigned FLEN       = 1 << N_LOG2;
    localparam int unsigned SW         = 2 * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              inv = 1'b0;
    logic              wr_en = 1'b0;
    logic [N_LOG2-1:0] wr_addr = '0;
    logic [SW-1:0]     wr_data = '0;
    logic              busy;
    logic              done;
    logic [15:0]       frame_cnt;
`ifdef FFT_FEED_LOOP_EN
    logic              loop = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [SW-1:0] ref_mem [FLEN];

    fft_frame_feeder_if #(.DATA_W(DATA_W), .CFG_W(CFG_W)) axis ();

    fft_frame_feeder #(
        .DATA_W     (DATA_W),
        .N_LOG2     (N_LOG2),
        .NUM_FRAMES (NUM_FRAMES),
        .CFG_W      (CFG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FFT_FEED_LOOP_EN
        .loop      (loop),
`endif
        .start     (start),
        .inv       (inv),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .axis      (axis),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_tvalid"}, axis.m_axis_data_tvalid, 0);
        chk({tag, "_data_tlast"},  axis.m_axis_data_tlast, 0);
        chk({tag, "_data_tdata"},  axis.m_axis_data_tdata, 0);
        chk({tag, "_cfg_tvalid"},  axis.m_axis_config_tvalid, 0);
        chk({tag, "_cfg_tdata"},   axis.m_axis_config_tdata, 0);
        chk({tag, "_busy"},        busy, 0);
        chk({tag, "_done"},        done, 0);
        chk({tag, "_frame_cnt"},   frame_cnt, 0);
    endtask

    // Fill the whole buffer; ramp=1 gives re=i, im=0, otherwise random samples.
    task automatic load_buf(input bit ramp);
        for (int i = 0; i < int'(FLEN); i++) begin
            wr_en   = 1'b1;
            wr_addr = N_LOG2'(i);
            wr_data = ramp ? SW'(i) : SW'($urandom);
            ref_mem[i] = wr_data;
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // One run: start, config handshake, stream and score every beat, then check completion.
    task automatic do_run(input bit inv_i, input int rdy_pct, input int cfg_hold,
                          input bit mid_poke, input int abort_beat, input bit wr_with_start,
                          input int passes);
        int total;
        int beat = 0;
        int edge_n = 0;
        int hs_edge = -1;
        int rise_edge = -1;
        int done_cnt = 0;
        int cfg_extra = 0;
        int tlast_cnt = 0;
        int bubbles = 0;
        int stab_err = 0;
        int budget;
        int addr;
        bit cfg_ok = 1'b1;
        bit stalled = 1'b0;
        bit poked = 1'b0;
        bit rdy;
        logic [SW:0] held = '0;

        total  = int'(FLEN * NUM_FRAMES) * passes;
        budget = total * 20 + cfg_hold + 200;
        axis.m_axis_config_tready = 1'b0;
        axis.m_axis_data_tready   = 1'b0;
        start = 1'b1;
        inv   = inv_i;
        if (wr_with_start) begin
            wr_en   = 1'b1;
            wr_addr = N_LOG2'(5);
            wr_data = 32'h1234_5678;
            ref_mem[5] = wr_data;
        end
        @(negedge clk);
        edge_n++;
        start = 1'b0;
        wr_en = 1'b0;
        inv   = ~inv_i;
        chk("cfg_tvalid_after_start", axis.m_axis_config_tvalid, 1);
        chk("cfg_tdata", axis.m_axis_config_tdata, CFG_W'(!inv_i));
        chk("busy_after_start", busy, 1);

        for (int c = 0; c < budget && !(beat >= total && done_cnt > 0); c++) begin
            start = 1'b0;
            wr_en = 1'b0;
`ifdef FFT_FEED_LOOP_EN
            loop = ((beat / int'(FLEN * NUM_FRAMES)) < passes - 1);
`endif
            if (beat == abort_beat) begin
                chk("busy_before_abort", busy, 1);
                axis.m_axis_data_tready = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_all_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (done) done_cnt++;
            if (axis.m_axis_data_tvalid && rise_edge < 0) rise_edge = edge_n;
            if (hs_edge < 0) begin
                if (!axis.m_axis_config_tvalid || axis.m_axis_data_tvalid) cfg_ok = 1'b0;
                axis.m_axis_config_tready = (c >= cfg_hold);
                if (axis.m_axis_config_tvalid && axis.m_axis_config_tready) hs_edge = edge_n + 1;
            end else begin
                if (axis.m_axis_config_tvalid) cfg_extra++;
                axis.m_axis_config_tready = 1'($urandom_range(0, 1));
            end

            if (stalled && (!axis.m_axis_data_tvalid ||
                            {axis.m_axis_data_tlast, axis.m_axis_data_tdata} !== held))
                stab_err++;
            if (rise_edge >= 0 && beat < total && !axis.m_axis_data_tvalid) bubbles++;
            rdy = ($urandom_range(0, 99) < rdy_pct);
            axis.m_axis_data_tready = rdy;
            stalled = axis.m_axis_data_tvalid && !rdy;
            held = {axis.m_axis_data_tlast, axis.m_axis_data_tdata};
            if (axis.m_axis_data_tvalid && rdy) begin
                addr = beat % int'(FLEN);
                if (beat < total) begin
                    chk("beat_data", axis.m_axis_data_tdata, ref_mem[addr]);
                    chk("beat_last", axis.m_axis_data_tlast, addr == int'(FLEN) - 1);
                end else begin
                    chk("beat_after_end", 1, 0);
                end
                if (axis.m_axis_data_tlast) tlast_cnt++;
                beat++;
            end
            if (mid_poke && !poked && beat >= 1) begin
                poked   = 1'b1;
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = N_LOG2'(5);
                wr_data = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            edge_n++;
        end

        axis.m_axis_data_tready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            if (done) done_cnt++;
            if (axis.m_axis_data_tvalid) stab_err++;
            @(negedge clk);
        end
        axis.m_axis_config_tready = 1'b0;

        chk("beats", beat, total);
        chk("tlast_cnt", tlast_cnt, NUM_FRAMES * passes);
        chk("stable_while_stalled", stab_err, 0);
        chk("cfg_held_no_data", cfg_ok, 1);
        chk("cfg_issued_once", cfg_extra, 0);
        chk("data_latency", rise_edge - hs_edge, 2);
        if (rdy_pct >= 100) chk("bubbles", bubbles, 0);
        chk("done_pulses", done_cnt, 1);
        chk("busy_after_run", busy, 0);
        chk("frame_cnt", frame_cnt, (NUM_FRAMES * passes) % 65536);
    endtask

    initial begin
        axis.m_axis_config_tready = 1'b0;
        axis.m_axis_data_tready   = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp frame, forward, full throughput.
        load_buf(1'b1);
        do_run(1'b0, 100, 0, 1'b0, -1, 1'b0, 1);

        // Random samples, inverse, 50% backpressure.
        load_buf(1'b0);
        do_run(1'b1, 50, 0, 1'b0, -1, 1'b0, 1);

        // Config stalled 20 cycles.
        do_run(1'b0, 100, 20, 1'b0, -1, 1'b0, 1);

        // Write and start during a run are both ignored.
        do_run(1'b0, 70, 3, 1'b1, -1, 1'b0, 1);
        chk("frozen_write_dropped", ref_mem[5] !== 32'hDEAD_BEEF, 1);

        // Write in the same idle cycle as start lands before the first read.
        do_run(1'b1, 80, 0, 1'b0, -1, 1'b1, 1);

        // Reset mid-run, then a clean run from address 0.
        do_run(1'b0, 100, 0, 1'b0, 300, 1'b0, 1);
        do_run(1'b0, 60, 0, 1'b0, -1, 1'b0, 1);

`ifdef FFT_FEED_LOOP_EN
        do_run(1'b0, 100, 0, 1'b0, -1, 1'b0, 2);
        do_run(1'b1, 50, 2, 1'b0, -1, 1'b0, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
